// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the rv32i memory stage (master)
// and the data-memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: word RAM with byte/half lanes,
// load extension, misalignment/illegal-funct3 errors and fixed response latency.
//
// state  | meaning
// S_IDLE | ready for a request (req_ready=1)
// S_WAIT | request captured, counting out the latency
// S_RESP | response presented, held until rsp_ready
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic   clk_i,
  input  logic   reset_i,
  dmem_if.slave  bus
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAST = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            src_we;
  logic [AW+1:0]   src_addr;
  logic [31:0]     src_wdata;
  logic [2:0]      src_f3;
  logic [AW-1:0]   widx;
  logic [31:0]     word_rd;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic            misalign, illegal, err_c;
  logic [3:0]      be;
  logic [31:0]     wword;
  logic [31:0]     load_val;
  logic            enter_resp;
  logic            commit;
  logic            unused_addr;

  assign unused_addr = ^bus.req_addr[31:AW+2];

  // With LATENCY=1 the RAM access happens on the acceptance edge itself, so
  // decode from the live bus while idle and from the captured copy otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      src_we    = bus.req_we;
      src_addr  = bus.req_addr[AW+1:0];
      src_wdata = bus.req_wdata;
      src_f3    = bus.req_funct3;
    end else begin
      src_we    = we_q;
      src_addr  = addr_q;
      src_wdata = wdata_q;
      src_f3    = f3_q;
    end
  end

  always_comb begin
    widx     = src_addr[AW+1:2];
    word_rd  = mem_q[widx];
    lane_b   = word_rd[{src_addr[1:0], 3'b000} +: 8];
    lane_h   = word_rd[{src_addr[1], 4'b0000} +: 16];
    misalign = 1'b0;
    illegal  = 1'b0;
    case (src_f3)
      3'b000:  ;
      3'b001:  misalign = src_addr[0];
      3'b010:  misalign = |src_addr[1:0];
      3'b100:  illegal  = src_we;
      3'b101:  begin
        misalign = src_addr[0];
        illegal  = src_we;
      end
      default: illegal  = 1'b1;
    endcase
    err_c = misalign | illegal;

    case (src_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << src_addr[1:0];
        wword = {4{src_wdata[7:0]}};
      end
      2'b01: begin
        be    = src_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{src_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = src_wdata;
      end
    endcase

    case (src_f3)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_val = {24'h0, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_val = {16'h0, lane_h};
      3'b010:  load_val = word_rd;
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr[AW+1:0];
          wdata_d = bus.req_wdata;
          f3_d    = bus.req_funct3;
          if (LATENCY > 1) begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end else begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = (err_c || src_we) ? 32'h0 : load_val;
      err_d   = err_c;
    end
  end

  assign commit = enter_resp & src_we & ~err_c & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      f3_q    <= 3'b000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; only unmasked lanes are written.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
